conv_layer_scheduler: RTL
=========================

// Module: conv_layer_scheduler
// PURPOSE
//  Top-level sequencer for one convolution layer on the systolic array. Per filter it runs four stages in order:
//  weight fill (weight_fill_control), input fill (feature-map fill, first filter only), compute (array), then result store.
//  Generates every stage's base address and reports layer completion and configuration errors to the host controller.
// PARAMETERS
//  ARRAY_SIZE     9   systolic array side; the largest legal weight_size
//  DIM_DATA_SIZE  16  width of the dimension and count inputs
//  ADDR_WIDTH     15  BRAM address width
// PORTS
//  clk              in   1              rising-edge clock
//  reset            in   1              synchronous, active-low reset
//  start            in   1              one-cycle pulse; sampled only in IDLE
//  input_size       in   DIM_DATA_SIZE  feature-map side N (square map)
//  weight_size      in   DIM_DATA_SIZE  kernel side K
//  number_filters   in   DIM_DATA_SIZE  filter count F
//  weight_base      in   ADDR_WIDTH     address of filter 0 weights
//  input_base       in   ADDR_WIDTH     address of the feature map
//  output_base      in   ADDR_WIDTH     address of filter 0 output
//  wfill_enable     out  1              level; drives weight_fill_control enable
//  wfill_address    out  ADDR_WIDTH     weight address for the current filter
//  wfill_done       in   1              weight fill complete
//  ifill_enable     out  1              level; input fill request
//  ifill_address    out  ADDR_WIDTH     equal to the latched input_base
//  ifill_done       in   1              input fill complete
//  compute_enable   out  1              level; array run request
//  compute_done     in   1              array run complete
//  store_enable     out  1              level; result writeback request
//  store_address    out  ADDR_WIDTH     output address for the current filter
//  store_done       in   1              writeback complete
//  filter_index     out  DIM_DATA_SIZE  index of the filter being processed
//  busy             out  1              high in every state except IDLE
//  done             out  1              one-cycle pulse when the layer completes
//  error            out  1              one-cycle pulse when the configuration is rejected
// BEHAVIOUR
//  Reset (reset==0 at posedge): state=IDLE.
//   - All outputs go to 0 on that edge, including a reset applied mid-layer; no partial work resumes.
//  States: IDLE, CHECK, WFILL, IFILL, COMPUTE, STORE, NEXT, FINISH.
//  IDLE: on start==1, latch all config inputs; go to CHECK. Config inputs are ignored at all other times.
//  CHECK (1 cycle): go to IDLE with error pulse if K==0, K>ARRAY_SIZE, F==0, or K>N. Otherwise go to WFILL.
//   - On entering WFILL: filter_index=0, wfill_address=weight_base, store_address=output_base.
//   - Precompute wstride=K*K and ostride=(N-K+1)^2. Both are truncated to ADDR_WIDTH.
//  Stage states WFILL/IFILL/COMPUTE/STORE:
//   - The matching *_enable is high for the whole state, including the entry cycle, and low in every other state.
//   - The stage's *_done is ignored on the entry cycle (stale-done protection). It is sampled on every later edge.
//   - Sampled done==1 advances the state, so enable drops on the edge after done is seen. There is no timeout.
//  Order: WFILL -> IFILL (only if filter_index==0) -> COMPUTE -> STORE -> NEXT.
//   - For filter_index>0, WFILL goes directly to COMPUTE.
//  NEXT (1 cycle):
//   - If filter_index==F-1, go to FINISH.
//   - Otherwise: filter_index+=1, wfill_address+=wstride, store_address+=ostride (both mod 2^ADDR_WIDTH); go to WFILL.
//  FINISH: done=1 for exactly one cycle; go to IDLE. Addresses and filter_index hold until the next start.
//  A done input asserted outside its own stage has no effect. start while busy is ignored.
//  Minimum per-filter cost: stage latencies + 2 cycles per stage + 1 (NEXT).
// STRUCTURE
//  cnn_sched_pkg:
//   - state enum, ARRAY_SIZE, DIM_DATA_SIZE, ADDR_WIDTH defaults.
//   - error cause codes (ERR_K_ZERO, ERR_K_BIG, ERR_F_ZERO, ERR_K_GT_N) for the bench.
//  One sub-module, sched_addr_stepper:
//   - holds the base/stride/current address registers and the filter counter.
//   - load/step controls come from the FSM.
//   - stride multiplies are registered in CHECK (single DSP; no combinational multiply on the address path).
// TESTING
//  Sub-block model: each stage asserts its done 3 cycles after its enable rises.
//  1. N=5, K=2, F=3, bases 0/100/200 -> wfill_address 0,4,8; store_address 200,216,232; ifill exactly once.
//     done pulses once; busy falls the same cycle done rises.
//  2. K=10 (>ARRAY_SIZE), F=1 -> error pulse 2 cycles after start; no enable ever rises; busy 1 cycle.
//  3. F=0 -> error. Then K=3, N=2 -> error. Then a valid start -> completes normally.
//  4. wfill_done held high before start -> WFILL still lasts >=2 cycles. A spurious compute_done during WFILL is ignored.
//  5. reset=0 during COMPUTE of filter 1 -> all outputs 0 next edge. A fresh start restarts at filter 0 with ifill repeated.
//  6. weight_base=32760, K=3, F=2 -> second wfill_address=1 (wrap mod 2^15). start pulses while busy are ignored.

Source files
------------

// File: rtl/cnn_sched_pkg.sv
// Shared types and default sizes for the convolution layer scheduler.
package cnn_sched_pkg;

  localparam int DFLT_ARRAY_SIZE = 9;
  localparam int DFLT_DIM_DATA_SIZE = 16;
  localparam int DFLT_ADDR_WIDTH = 15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_WFILL,
    ST_IFILL,
    ST_COMPUTE,
    ST_STORE,
    ST_NEXT,
    ST_FINISH
  } state_e;

  typedef enum logic [2:0] {
    ERR_NONE,
    ERR_K_ZERO,
    ERR_K_BIG,
    ERR_F_ZERO,
    ERR_K_GT_N
  } err_e;

endpackage

// File: rtl/conv_layer_scheduler_if.sv
// Stage handshake bundle between the scheduler and its fill/compute/store units.
interface conv_layer_scheduler_if #(
  parameter int ADDR_WIDTH = cnn_sched_pkg::DFLT_ADDR_WIDTH
);

  logic                  wfill_enable;
  logic [ADDR_WIDTH-1:0] wfill_address;
  logic                  wfill_done;
  logic                  ifill_enable;
  logic [ADDR_WIDTH-1:0] ifill_address;
  logic                  ifill_done;
  logic                  compute_enable;
  logic                  compute_done;
  logic                  store_enable;
  logic [ADDR_WIDTH-1:0] store_address;
  logic                  store_done;

  modport master (
    output wfill_enable,
    output wfill_address,
    input  wfill_done,
    output ifill_enable,
    output ifill_address,
    input  ifill_done,
    output compute_enable,
    input  compute_done,
    output store_enable,
    output store_address,
    input  store_done
  );

  modport slave (
    input  wfill_enable,
    input  wfill_address,
    output wfill_done,
    input  ifill_enable,
    input  ifill_address,
    output ifill_done,
    input  compute_enable,
    output compute_done,
    input  store_enable,
    input  store_address,
    output store_done
  );

endinterface

// File: rtl/sched_addr_stepper.sv
// Base/stride/current address registers and filter counter.
module sched_addr_stepper
  import cnn_sched_pkg::*;
#(
  parameter int DIM_DATA_SIZE = DFLT_DIM_DATA_SIZE,
  parameter int ADDR_WIDTH = DFLT_ADDR_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     latch,
  input  logic                     calc,
  input  logic                     load,
  input  logic                     step,
  input  logic [ADDR_WIDTH-1:0]    weight_base,
  input  logic [ADDR_WIDTH-1:0]    input_base,
  input  logic [ADDR_WIDTH-1:0]    output_base,
  input  logic [DIM_DATA_SIZE-1:0] k,
  input  logic [DIM_DATA_SIZE-1:0] n,
  output logic [ADDR_WIDTH-1:0]    wfill_address,
  output logic [ADDR_WIDTH-1:0]    ifill_address,
  output logic [ADDR_WIDTH-1:0]    store_address,
  output logic [DIM_DATA_SIZE-1:0] filter_index
);

  logic [ADDR_WIDTH-1:0]    wb_q;
  logic [ADDR_WIDTH-1:0]    ob_q;
  logic [ADDR_WIDTH-1:0]    wstride;
  logic [ADDR_WIDTH-1:0]    ostride;
  logic [DIM_DATA_SIZE-1:0] side;

  // Output map side; only meaningful once K<=N has been checked.
  assign side = n - k + DIM_DATA_SIZE'(1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      wb_q          <= '0;
      ob_q          <= '0;
      wstride       <= '0;
      ostride       <= '0;
      wfill_address <= '0;
      ifill_address <= '0;
      store_address <= '0;
      filter_index  <= '0;
    end else begin
      if (latch) begin
        wb_q          <= weight_base;
        ob_q          <= output_base;
        ifill_address <= input_base;
      end
      if (calc) begin
        wstride <= ADDR_WIDTH'(k * k);
        ostride <= ADDR_WIDTH'(side * side);
      end
      if (load) begin
        wfill_address <= wb_q;
        store_address <= ob_q;
        filter_index  <= '0;
      end else if (step) begin
        wfill_address <= wfill_address + wstride;
        store_address <= store_address + ostride;
        filter_index  <= filter_index + DIM_DATA_SIZE'(1);
      end
    end
  end

endmodule

// File: rtl/conv_layer_scheduler.sv
// Per-layer sequencer: weight fill, input fill, compute and store per filter.
module conv_layer_scheduler
  import cnn_sched_pkg::*;
#(
  parameter int ARRAY_SIZE = DFLT_ARRAY_SIZE,
  parameter int DIM_DATA_SIZE = DFLT_DIM_DATA_SIZE,
  parameter int ADDR_WIDTH = DFLT_ADDR_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [DIM_DATA_SIZE-1:0] input_size,
  input  logic [DIM_DATA_SIZE-1:0] weight_size,
  input  logic [DIM_DATA_SIZE-1:0] number_filters,
  input  logic [ADDR_WIDTH-1:0]    weight_base,
  input  logic [ADDR_WIDTH-1:0]    input_base,
  input  logic [ADDR_WIDTH-1:0]    output_base,
  conv_layer_scheduler_if.master   stg,
  output logic [DIM_DATA_SIZE-1:0] filter_index,
  output logic                     busy,
  output logic                     done,
  output logic                     error
);

  state_e                   state;
  state_e                   state_n;
  logic                     armed;
  logic                     step;
  logic                     latch;
  logic                     cfg_ok;
  logic                     first;
  logic                     last;
  err_e                     cause;
  logic [DIM_DATA_SIZE-1:0] cfg_k;
  logic [DIM_DATA_SIZE-1:0] cfg_n;
  logic [DIM_DATA_SIZE-1:0] cfg_f;

  assign latch  = (state == ST_IDLE) && start;
  assign cfg_ok = (cause == ERR_NONE);
  assign first  = (filter_index == '0);
  assign last   = (filter_index == cfg_f - DIM_DATA_SIZE'(1));

  always_comb begin
    cause = ERR_NONE;
    if (cfg_k == '0)
      cause = ERR_K_ZERO;
    else if (cfg_k > DIM_DATA_SIZE'(ARRAY_SIZE))
      cause = ERR_K_BIG;
    else if (cfg_f == '0)
      cause = ERR_F_ZERO;
    else if (cfg_k > cfg_n)
      cause = ERR_K_GT_N;
  end

  // armed is low on a stage's entry cycle so a stale done is ignored.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
      armed <= 1'b0;
      done  <= 1'b0;
      error <= 1'b0;
      cfg_k <= '0;
      cfg_n <= '0;
      cfg_f <= '0;
    end else begin
      state <= state_n;
      armed <= (state_n == state);
      done  <= (state == ST_FINISH);
      error <= (state == ST_CHECK) && !cfg_ok;
      if (latch) begin
        cfg_k <= weight_size;
        cfg_n <= input_size;
        cfg_f <= number_filters;
      end
    end
  end

  always_comb begin
    state_n = state;
    step    = 1'b0;
    unique case (state)
      ST_IDLE:
        if (start) state_n = ST_CHECK;
      ST_CHECK:
        state_n = cfg_ok ? ST_WFILL : ST_IDLE;
      ST_WFILL:
        if (armed && stg.wfill_done)
          state_n = first ? ST_IFILL : ST_COMPUTE;
      ST_IFILL:
        if (armed && stg.ifill_done) state_n = ST_COMPUTE;
      ST_COMPUTE:
        if (armed && stg.compute_done) state_n = ST_STORE;
      ST_STORE:
        if (armed && stg.store_done) state_n = ST_NEXT;
      ST_NEXT:
        if (last) begin
          state_n = ST_FINISH;
        end else begin
          step    = 1'b1;
          state_n = ST_WFILL;
        end
      ST_FINISH:
        state_n = ST_IDLE;
      default:
        state_n = ST_IDLE;
    endcase
  end

  assign stg.wfill_enable   = (state == ST_WFILL);
  assign stg.ifill_enable   = (state == ST_IFILL);
  assign stg.compute_enable = (state == ST_COMPUTE);
  assign stg.store_enable   = (state == ST_STORE);
  assign busy               = (state != ST_IDLE);

  sched_addr_stepper #(
    .DIM_DATA_SIZE(DIM_DATA_SIZE),
    .ADDR_WIDTH   (ADDR_WIDTH)
  ) u_step (
    .clk          (clk),
    .reset        (reset),
    .latch        (latch),
    .calc         (state == ST_CHECK),
    .load         ((state == ST_CHECK) && cfg_ok),
    .step         (step),
    .weight_base  (weight_base),
    .input_base   (input_base),
    .output_base  (output_base),
    .k            (cfg_k),
    .n            (cfg_n),
    .wfill_address(stg.wfill_address),
    .ifill_address(stg.ifill_address),
    .store_address(stg.store_address),
    .filter_index (filter_index)
  );

endmodule
